// File: rtl/seq_prio_enc_pkg.sv
// Shared types and default sizing for the sequential priority encoder.
package seq_prio_enc_pkg;

    localparam int N_DEF    = 8;
    localparam int IDXW_DEF = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/pri_find.sv
// Combinational lowest-set-bit finder: binary index of the lowest set bit plus an any-set flag.
module pri_find #(
    parameter int N    = 8,
    parameter int IDXW = 3
) (
    input  logic [N-1:0]    vec,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    always_comb begin
        idx = '0;
        any = |vec;
        // Scan from the top so the lowest set bit is the final assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/seq_prio_encoder.sv
// Sequential N-to-IDXW encoder: accepts a multi-hot vector and emits one index per beat.
// Build option SEQ_PRIO_ENC_MSB_FIRST_EN emits highest set index first instead of lowest.
module seq_prio_encoder
    import seq_prio_enc_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int IDXW = IDXW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last,
    output logic            out_none
);

    generate
        if (IDXW != $clog2(N)) begin : g_bad_idxw
            $error("seq_prio_encoder: IDXW must equal clog2(N)");
        end
    endgenerate

    state_t         state_reg, state_next;
    logic [N-1:0]   pend_reg, pend_next;
    logic           none_reg, none_next;

    logic [N-1:0]    search_vec;
    logic [IDXW-1:0] find_idx;
    logic            find_any;
    logic [IDXW-1:0] cur_idx;
    logic [N-1:0]    emit_mask;
    logic            single;

`ifdef SEQ_PRIO_ENC_MSB_FIRST_EN
    // Reverse the search so the finder's "lowest" is our highest set bit.
    for (genvar gi = 0; gi < N; gi++) begin : g_rev
        assign search_vec[gi] = pend_reg[N-1-gi];
    end
    assign cur_idx = IDXW'(N - 1) - find_idx;
`else
    assign search_vec = pend_reg;
    assign cur_idx    = find_idx;
`endif

    pri_find #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pri_find (
        .vec (search_vec),
        .idx (find_idx),
        .any (find_any)
    );

    assign emit_mask = N'(1) << cur_idx;
    // Exactly one bit left: this beat is the last of the vector.
    assign single    = find_any && ((pend_reg & (pend_reg - N'(1))) == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pend_reg  <= '0;
            none_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            none_reg  <= none_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pend_next  = pend_reg;
        none_next  = none_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_idx    = '0;
        out_last   = 1'b0;
        out_none   = 1'b0;

        unique case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pend_next  = in_vec;
                    none_next  = (in_vec == '0);
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_idx   = none_reg ? '0 : cur_idx;
                out_last  = none_reg || single;
                out_none  = none_reg;
                if (out_ready) begin
                    pend_next = pend_reg & ~emit_mask;
                    if (none_reg || single) begin
                        state_next = IDLE;
                        none_next  = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_prio_encoder.sv
// Directed self-checking bench for seq_prio_encoder (both ordering builds).
module tb_seq_prio_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       out_none;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_prio_encoder #(.N(8), .IDXW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_none  (out_none)
    );

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({out_valid, out_idx, out_last, out_none} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b idx=%0d last=%b none=%b, want all 0",
                     out_valid, out_idx, out_last, out_none);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
        $display("reset: done");
    endtask

    task automatic test_sparse();
`ifdef SEQ_PRIO_ENC_MSB_FIRST_EN
        logic [2:0] exp_idx [3] = '{3'd7, 3'd5, 3'd2};
`else
        logic [2:0] exp_idx [3] = '{3'd2, 3'd5, 3'd7};
`endif
        in_valid = 1'b1; in_vec = 8'b1010_0100; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_idx !== exp_idx[i] || out_last !== (i == 2) || out_none !== 1'b0) begin
                n_err++;
                $display("FAIL sparse_beat%0d: got v=%b idx=%0d last=%b none=%b, want v=1 idx=%0d last=%b none=0",
                         i, out_valid, out_idx, out_last, out_none, exp_idx[i], (i == 2));
            end
            $display("sparse beat %0d: idx=%0d last=%b", i, out_idx, out_last);
            @(negedge clk);
        end
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sparse_idle: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
`ifdef SEQ_PRIO_ENC_MSB_FIRST_EN
        logic [2:0] exp_idx [2] = '{3'd7, 3'd0};
`else
        logic [2:0] exp_idx [2] = '{3'd0, 3'd7};
`endif
        in_valid = 1'b1; in_vec = 8'h81; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_idx !== exp_idx[0] || out_last !== 1'b0 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b idx=%0d last=%b rdy=%b, want v=1 idx=%0d last=0 rdy=0",
                         c, out_valid, out_idx, out_last, in_ready, exp_idx[0]);
            end
            $display("backpressure stall %0d: idx=%0d", c, out_idx);
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_idx !== exp_idx[i] || out_last !== (i == 1)) begin
                n_err++;
                $display("FAIL bp_beat%0d: got v=%b idx=%0d last=%b, want v=1 idx=%0d last=%b",
                         i, out_valid, out_idx, out_last, exp_idx[i], (i == 1));
            end
            $display("backpressure beat %0d: idx=%0d last=%b", i, out_idx, out_last);
            @(negedge clk);
        end
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_idle: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_zero();
        in_valid = 1'b1; in_vec = 8'h00; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_last !== 1'b1 || out_none !== 1'b1) begin
            n_err++;
            $display("FAIL zero_beat: got v=%b idx=%0d last=%b none=%b, want v=1 idx=0 last=1 none=1",
                     out_valid, out_idx, out_last, out_none);
        end
        $display("zero beat: none=%b last=%b", out_none, out_last);
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_none !== 1'b0) begin
            n_err++;
            $display("FAIL zero_idle: got in_ready=%b out_valid=%b none=%b, want 1/0/0",
                     in_ready, out_valid, out_none);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp;
        in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
        @(negedge clk);
        in_vec = 8'h10;
        for (int i = 0; i < 8; i++) begin
`ifdef SEQ_PRIO_ENC_MSB_FIRST_EN
            exp = 3'(7 - i);
`else
            exp = 3'(i);
`endif
            n_vec++;
            if (out_valid !== 1'b1 || out_idx !== exp || out_last !== (i == 7) || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL full_beat%0d: got v=%b idx=%0d last=%b rdy=%b, want v=1 idx=%0d last=%b rdy=0",
                         i, out_valid, out_idx, out_last, in_ready, exp, (i == 7));
            end
            $display("full beat %0d: idx=%0d last=%b", i, out_idx, out_last);
            @(negedge clk);
        end
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_idle: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_idx !== 3'd4 || out_last !== 1'b1 || out_none !== 1'b0) begin
            n_err++;
            $display("FAIL held_vec_beat: got v=%b idx=%0d last=%b none=%b, want v=1 idx=4 last=1 none=0",
                     out_valid, out_idx, out_last, out_none);
        end
        $display("held vector beat: idx=%0d last=%b", out_idx, out_last);
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL held_idle: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_drain();
        logic [2:0] exp;
        in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
`ifdef SEQ_PRIO_ENC_MSB_FIRST_EN
            exp = 3'(7 - i);
`else
            exp = 3'(i);
`endif
            n_vec++;
            if (out_valid !== 1'b1 || out_idx !== exp) begin
                n_err++;
                $display("FAIL rstdrain_beat%0d: got v=%b idx=%0d, want v=1 idx=%0d", i, out_valid, out_idx, exp);
            end
            $display("reset-drain beat %0d: idx=%0d", i, out_idx);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || out_idx !== 3'd0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL rstdrain_cut: got v=%b idx=%0d last=%b, want 0/0/0", out_valid, out_idx, out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_vec++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rstdrain_idle%0d: got in_ready=%b out_valid=%b, want 1/0", c, in_ready, out_valid);
            end
        end
        $display("reset-drain: no further beats");
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_sparse();
        test_backpressure();
        test_zero();
        test_back_to_back();
        test_reset_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
